// File: rtl/mem_port_arbiter.sv
// Shares one external audio memory port between NREQ engines: a fixed high-priority
// requester, round-robin among the rest, one outstanding access, watchdog abort.
module mem_port_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 16,
  parameter int HIPRI   = 0,
  parameter int TIMEOUT = 1023
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     freeze,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     err,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   win, last, pick;
  logic [CNT_W-1:0]   cnt;
  logic               grant_en, finish_en, abort_en;

  logic [ADDR_W-1:0]  addr_arr  [NREQ];
  logic [DATA_W-1:0]  wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // Winner: HIPRI outright, otherwise the first requester after the last winner.
  always_comb begin
    int idx;
    logic found;
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pick  = IDX_W'(HIPRI);
    found = 1'b0;
    idx   = 0;
    if (!req[HIPRI]) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = int'(last) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && req[idx[IDX_W-1:0]]) begin
          pick  = idx[IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state;
    grant_en  = 1'b0;
    finish_en = 1'b0;
    abort_en  = 1'b0;
    case (state)
      IDLE: begin
        if (!freeze && |req) begin
          grant_en = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // An ack in the final watchdog cycle still completes normally.
        if (mem_ack) begin
          finish_en = 1'b1;
          state_d   = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          abort_en = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      win       <= '0;
      last      <= IDX_W'(NREQ - 1);
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      err  <= 1'b0;
      if (grant_en) begin
        win       <= pick;
        last      <= pick;
        gnt       <= NREQ'(1) << pick;
        cnt       <= '0;
        mem_req   <= 1'b1;
        mem_we    <= req_we[pick];
        mem_addr  <= addr_arr[pick];
        mem_wdata <= wdata_arr[pick];
      end
      if (state == BUSY) begin
        if (finish_en || abort_en) begin
          mem_req <= 1'b0;
          done    <= NREQ'(1) << win;
          err     <= abort_en;
          cnt     <= '0;
          if (finish_en && !mem_we) rdata <= mem_rdata;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: rule-abiding requesters and a random memory,
// compared each cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int NREQ    = 4;
  localparam int IW      = 2;
  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 16;
  localparam int HIPRI   = 0;
  localparam int TIMEOUT = 8;

  logic                   i_clk = 1'b0;
  logic                   i_rst = 1'b1;
  logic                   freeze = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ-1:0]        req_we = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ*DATA_W-1:0] req_wdata = '0;
  logic [DATA_W-1:0]      mem_rdata = '0;
  logic                   mem_ack = 1'b0;
  logic [NREQ-1:0]        gnt, done;
  logic                   err, mem_req, mem_we;
  logic [DATA_W-1:0]      rdata, mem_wdata;
  logic [ADDR_W-1:0]      mem_addr;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HIPRI(HIPRI), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .freeze(freeze),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, expected outputs for the current cycle.
  bit               m_busy;
  logic [IW-1:0]    m_win, m_last;
  int               m_age;
  logic [NREQ-1:0]  e_gnt, e_done;
  logic             e_err, e_mem_req, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_rdata;

  // Requester side: held request fields and whether an access is outstanding.
  bit               r_out   [NREQ];
  logic             r_we    [NREQ];
  logic [ADDR_W-1:0] r_addr [NREQ];
  logic [DATA_W-1:0] r_wdata[NREQ];
  int               ack_pct, req_pct, freeze_pct;

  // NREQ is 4, so IW-bit addition wraps modulo NREQ.
  function automatic logic [IW-1:0] pick_winner(input logic [NREQ-1:0] r, input logic [IW-1:0] last);
    logic [IW-1:0] j;
    if (r[HIPRI]) return IW'(HIPRI);
    for (int k = 1; k <= NREQ; k++) begin
      j = last + IW'(k);
      if (r[j]) return j;
    end
    return last;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_win = '0; m_last = IW'(NREQ - 1); m_age = 0;
    e_gnt = '0; e_done = '0; e_err = 0; e_mem_req = 0; e_we = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      r_out[i] = 0; r_we[i] = 0; r_addr[i] = '0; r_wdata[i] = '0;
    end
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    freeze = 0; mem_ack = 0;
  endtask

  task automatic model_step();
    logic [IW-1:0] w;
    e_gnt = '0; e_done = '0; e_err = 0;
    if (!m_busy) begin
      if (!freeze && req != '0) begin
        w = pick_winner(req, m_last);
        m_last = w; m_win = w; m_busy = 1; m_age = 0;
        e_gnt[w] = 1'b1;
        e_mem_req = 1; e_we = r_we[w]; e_addr = r_addr[w]; e_wdata = r_wdata[w];
      end
    end else begin
      m_age++;
      if (mem_ack) begin
        e_done[m_win] = 1'b1;
        if (!e_we) e_rdata = mem_rdata;
        m_busy = 0; e_mem_req = 0;
      end else if (m_age == TIMEOUT) begin
        e_done[m_win] = 1'b1; e_err = 1;
        m_busy = 0; e_mem_req = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("gnt", 64'(gnt), 64'(e_gnt));
    check("done", 64'(done), 64'(e_done));
    check("err", 64'(err), 64'(e_err));
    check("rdata", 64'(rdata), 64'(e_rdata));
    check("mem_req", 64'(mem_req), 64'(e_mem_req));
    check("mem_we", 64'(mem_we), 64'(e_we));
    check("mem_addr", 64'(mem_addr), 64'(e_addr));
    check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
  endtask

  // Called at a negedge: react to this cycle's gnt/done, pick new inputs, advance the model.
  task automatic drive_cycle();
    for (int i = 0; i < NREQ; i++) begin
      if (e_done[i]) r_out[i] = 0;
      if (e_gnt[i]) begin
        // Latched copy must survive the requester scribbling over its fields.
        req[i] = 1'b0;
        r_we[i] = 1'($urandom); r_addr[i] = ADDR_W'($urandom); r_wdata[i] = DATA_W'($urandom);
      end else if (!r_out[i] && !req[i] && $urandom_range(99) < req_pct) begin
        req[i] = 1'b1; r_out[i] = 1;
        r_we[i] = 1'($urandom); r_addr[i] = ADDR_W'($urandom); r_wdata[i] = DATA_W'($urandom);
      end
      req_we[i] = r_we[i];
      req_addr[i*ADDR_W +: ADDR_W] = r_addr[i];
      req_wdata[i*DATA_W +: DATA_W] = r_wdata[i];
    end
    freeze    = ($urandom_range(99) < freeze_pct);
    mem_ack   = ($urandom_range(99) < ack_pct);
    mem_rdata = DATA_W'($urandom);
    model_step();
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      drive_cycle();
      @(negedge i_clk);
      check_outputs();
    end
  endtask

  initial begin
    int n;
    model_reset();
    ack_pct = 35; req_pct = 30; freeze_pct = 15;
    i_rst = 1;
    repeat (3) @(negedge i_clk);
    check_outputs();
    i_rst = 0;

    run_cycles(1500);
    ack_pct = 4;                 // long stalls drive accesses into the watchdog
    run_cycles(700);
    ack_pct = 35; freeze_pct = 100; req_pct = 80;
    run_cycles(60);              // frozen: in-flight access finishes, nothing new granted
    freeze_pct = 10; req_pct = 50; ack_pct = 60;
    run_cycles(700);

    n = 0;
    ack_pct = 0;
    while (!e_mem_req && n < 100) begin
      run_cycles(1);
      n++;
    end
    check("busy_before_reset", 64'(mem_req), 64'(1));
    #1 i_rst = 1;
    #1;
    model_reset();
    check_outputs();
    @(negedge i_clk);
    check_outputs();
    i_rst = 0;
    ack_pct = 35; req_pct = 30; freeze_pct = 15;
    run_cycles(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
